// File: rtl/gesture_spi_framer.sv
// gesture_spi_framer
//
// Frames one gesture result (id + x/y centroid) into a fixed 7-byte packet
// and feeds it byte by byte to the SPI byte transmitter:
//   byte 0 HEADER_BYTE, 1 gesture, 2 x[15:8], 3 x[7:0], 4 y[15:8], 5 y[7:0],
//   byte 6 checksum = sum of bytes 1..5 mod 256.
// Coordinates are zero-extended to 16 bits before being split into bytes.
//
// Handshakes:
//   Upstream: a result is taken on a clk_in edge where valid_in && ready_out.
//   ready_out is high only while idle, so there is no back-pressure beyond it;
//   valid_in seen while ready_out is low is counted as a drop.
//   Downstream: a byte is handed over by a one-cycle spi_trigger_out with
//   spi_data_out stable; the transmitter acknowledges by pulling spi_sel_in
//   low and signals completion by returning it high. A trigger is only ever
//   issued while spi_sel_in is high.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   valid_in, ready_out   upstream result handshake
//   gesture_in, x_in, y_in  result fields
//   spi_sel_in            transmitter select (1 = idle, 0 = shifting)
//   spi_data_out          byte presented to the transmitter
//   spi_trigger_out       one-cycle start pulse to the transmitter
//   busy_out              packet in progress
//   done_out              one-cycle pulse when the last byte completes
//   drop_count_out        saturating count of refused result cycles
module gesture_spi_framer #(
    parameter int unsigned COORD_WIDTH = 11,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [7:0]             gesture_in,
    input  logic [COORD_WIDTH-1:0] x_in,
    input  logic [COORD_WIDTH-1:0] y_in,
    input  logic                   spi_sel_in,
    output logic [7:0]             spi_data_out,
    output logic                   spi_trigger_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [7:0]             drop_count_out
);

    // Gap counter loads GAP_CYCLES-1 and counts down to 0, so the GAP state
    // is occupied for exactly GAP_CYCLES cycles.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t           state;
    logic [2:0]       byte_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       gesture_q;
    logic [15:0]      x_q;
    logic [15:0]      y_q;
    logic [7:0]       csum_q;

    logic [15:0]      x_ext;
    logic [15:0]      y_ext;
    logic [7:0]       csum_next;
    logic [7:0]       cur_byte;

    assign x_ext = 16'(x_in);
    assign y_ext = 16'(y_in);

    // Checksum is formed from the live inputs at the capture edge so the
    // latched packet is complete the moment it is taken.
    assign csum_next = gesture_in + x_ext[15:8] + x_ext[7:0]
                     + y_ext[15:8] + y_ext[7:0];

    always_comb begin
        cur_byte = HEADER_BYTE;
        case (byte_idx)
            3'd0:    cur_byte = HEADER_BYTE;
            3'd1:    cur_byte = gesture_q;
            3'd2:    cur_byte = x_q[15:8];
            3'd3:    cur_byte = x_q[7:0];
            3'd4:    cur_byte = y_q[15:8];
            3'd5:    cur_byte = y_q[7:0];
            3'd6:    cur_byte = csum_q;
            default: cur_byte = HEADER_BYTE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= S_IDLE;
            ready_out       <= 1'b1;
            spi_trigger_out <= 1'b0;
            spi_data_out    <= 8'd0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            drop_count_out  <= 8'd0;
            byte_idx        <= 3'd0;
            gap_cnt         <= '0;
            gesture_q       <= 8'd0;
            x_q             <= 16'd0;
            y_q             <= 16'd0;
            csum_q          <= 8'd0;
        end else begin
            spi_trigger_out <= 1'b0;
            done_out        <= 1'b0;

            if (valid_in && !ready_out && (drop_count_out != 8'hFF)) begin
                drop_count_out <= drop_count_out + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (valid_in && ready_out) begin
                        gesture_q <= gesture_in;
                        x_q       <= x_ext;
                        y_q       <= y_ext;
                        csum_q    <= csum_next;
                        byte_idx  <= 3'd0;
                        ready_out <= 1'b0;
                        busy_out  <= 1'b1;
                        state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (spi_sel_in) begin
                        spi_data_out    <= cur_byte;
                        spi_trigger_out <= 1'b1;
                        state           <= S_WAIT_ACK;
                    end
                end

                // Select is still high in the cycle the trigger is visible;
                // only the falling select counts as the acknowledge.
                S_WAIT_ACK: begin
                    if (!spi_sel_in) begin
                        state <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (spi_sel_in) begin
                        if (byte_idx == LAST_IDX) begin
                            state     <= S_IDLE;
                            done_out  <= 1'b1;
                            ready_out <= 1'b1;
                            busy_out  <= 1'b0;
                            byte_idx  <= 3'd0;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            if (GAP_CYCLES == 0) begin
                                state <= S_SEND;
                            end else begin
                                gap_cnt <= GAP_LOAD;
                                state   <= S_GAP;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gesture_spi_framer.sv
// Bench for gesture_spi_framer: directed packets from the test plan plus
// randomized packets, checked against a packet model and a behavioural
// SPI transmitter that acknowledges each trigger.
module tb_gesture_spi_framer;

    localparam int         CW  = 11;
    localparam int         GAP = 4;
    localparam logic [7:0] HDR = 8'hA5;

    // ---------------- clock / reset ----------------
    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          valid_in = 1'b0;
    logic [7:0]    gesture_in = 8'd0;
    logic [CW-1:0] x_in = '0;
    logic [CW-1:0] y_in = '0;
    logic          spi_sel;
    logic          ready_out, spi_trigger_out, busy_out, done_out;
    logic [7:0]    spi_data_out, drop_count_out;

    always #5 clk_in = ~clk_in;

    gesture_spi_framer #(
        .COORD_WIDTH(CW),
        .HEADER_BYTE(HDR),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .gesture_in     (gesture_in),
        .x_in           (x_in),
        .y_in           (y_in),
        .spi_sel_in     (spi_sel),
        .spi_data_out   (spi_data_out),
        .spi_trigger_out(spi_trigger_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .drop_count_out (drop_count_out)
    );

    // ---------------- scoreboard state ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          drop_exp = 0;
    int          trig_count = 0;
    int          done_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Packet model: header, gesture, 16-bit zero-extended x and y big-endian,
    // then the byte sum of the payload modulo 256.
    task automatic model_packet(input logic [7:0] g, input logic [CW-1:0] x, input logic [CW-1:0] y);
        int xv, yv, s;
        xv = int'(x);
        yv = int'(y);
        exp_q.delete();
        exp_q.push_back(HDR);
        exp_q.push_back(g);
        exp_q.push_back(8'(xv / 256));
        exp_q.push_back(8'(xv % 256));
        exp_q.push_back(8'(yv / 256));
        exp_q.push_back(8'(yv % 256));
        s = int'(g) + xv / 256 + xv % 256 + yv / 256 + yv % 256;
        exp_q.push_back(8'(s % 256));
    endtask

    // ---------------- behavioural SPI transmitter ----------------
    // Sees the trigger, drops select one cycle later, holds it low for
    // tx_low cycles, then releases it. hold_low lets the bench keep select
    // low independently to model a busy transmitter.
    logic tx_sel = 1'b1;
    logic hold_low = 1'b0;
    int   tx_low = 8;
    int   tx_phase = 0;
    int   low_cnt = 0;
    int   since_rise = 0;
    logic expect_gap = 1'b0;
    logic done_prev = 1'b0;

    assign spi_sel = tx_sel & ~hold_low;

    always @(negedge clk_in) begin
        if (rst_in) begin
            tx_sel     = 1'b1;
            tx_phase   = 0;
            expect_gap = 1'b0;
            done_prev  = 1'b0;
        end else begin
            since_rise++;
            if (spi_trigger_out) begin
                chk("trigger_while_sel_low", spi_sel, 1'b1);
                // Rise sampled at edge E0, GAP idle cycles, trigger from SEND:
                // trigger is visible GAP+2 falling edges after the release.
                if (expect_gap) chk("gap_timing", since_rise, GAP + 2);
                got_q.push_back(spi_data_out);
                trig_count++;
                expect_gap = 1'b0;
                tx_phase   = 1;
            end else if (tx_phase == 1) begin
                tx_sel   = 1'b0;
                low_cnt  = 0;
                tx_phase = 2;
            end else if (tx_phase == 2) begin
                low_cnt++;
                if (low_cnt >= tx_low) begin
                    tx_sel     = 1'b1;
                    tx_phase   = 0;
                    since_rise = 0;
                    expect_gap = 1'b1;
                end
            end
            if (done_out) begin
                chk("done_single_cycle", done_prev, 1'b0);
                done_count++;
                expect_gap = 1'b0;
            end
            done_prev = done_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int t = 0;
        while (ready_out !== 1'b1 && t < 200) begin
            @(negedge clk_in);
            t++;
        end
        chk("ready_before_capture", ready_out, 1'b1);
    endtask

    task automatic capture(input logic [7:0] g, input logic [CW-1:0] x, input logic [CW-1:0] y);
        valid_in   = 1'b1;
        gesture_in = g;
        x_in       = x;
        y_in       = y;
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in   = 1'b0;
        // Later input changes must not reach the packet in flight.
        gesture_in = 8'($urandom);
        x_in       = CW'($urandom);
        y_in       = CW'($urandom);
    endtask

    task automatic run_packet(input logic [7:0] g, input logic [CW-1:0] x, input logic [CW-1:0] y,
                              input int drops, input int hold);
        int t, tc0;
        model_packet(g, x, y);
        wait_ready();
        got_q.delete();
        if (hold > 0) hold_low = 1'b1;
        tc0 = trig_count;
        capture(g, x, y);
        chk("busy_after_capture", busy_out, 1'b1);
        chk("ready_after_capture", ready_out, 1'b0);
        chk("no_trigger_first_cycle", spi_trigger_out, 1'b0);
        if (hold > 0) begin
            repeat (hold) @(negedge clk_in);
            chk("no_trigger_while_held", trig_count - tc0, 0);
            hold_low = 1'b0;
        end else begin
            @(negedge clk_in);
            chk("first_trigger_latency", spi_trigger_out, 1'b1);
        end
        if (drops > 0) begin
            valid_in = 1'b1;
            repeat (drops) @(negedge clk_in);
            valid_in = 1'b0;
            drop_exp = (drop_exp + drops > 255) ? 255 : drop_exp + drops;
        end
        t = 0;
        while (done_out !== 1'b1 && t < 4000) begin
            @(negedge clk_in);
            t++;
        end
        chk("done_seen", done_out, 1'b1);
        chk("ready_with_done", ready_out, 1'b1);
        chk("busy_clear_with_done", busy_out, 1'b0);
        chk("drop_count", drop_count_out, drop_exp);
        chk("packet_len", got_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < got_q.size()) chk($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int t, dc0;
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("rst_ready", ready_out, 1'b1);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_trigger", spi_trigger_out, 1'b0);
        chk("rst_data", spi_data_out, 8'd0);
        chk("rst_done", done_out, 1'b0);
        chk("rst_drop", drop_count_out, 8'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        tx_low = 8;
        run_packet(8'h03, CW'(640), CW'(360), 0, 0);
        run_packet(8'hFF, CW'(2047), CW'(2047), 10, 0);
        run_packet(8'($urandom), CW'($urandom), CW'($urandom), 0, 20);
        tx_low = 60;
        run_packet(8'($urandom), CW'($urandom), CW'($urandom), 300, 0);

        for (int k = 0; k < 6; k++) begin
            tx_low = $urandom_range(2, 8);
            run_packet(8'($urandom), CW'($urandom), CW'($urandom), int'($urandom_range(0, 3)), 0);
        end

        // Reset while byte 3 is with the transmitter.
        tx_low = 6;
        wait_ready();
        got_q.delete();
        capture(8'($urandom), CW'($urandom), CW'($urandom));
        t = 0;
        while (got_q.size() < 4 && t < 1000) begin
            @(negedge clk_in);
            t++;
        end
        chk("reached_byte3", (got_q.size() >= 4) ? 1 : 0, 1);
        dc0 = done_count;
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("midrst_busy", busy_out, 1'b0);
        chk("midrst_ready", ready_out, 1'b1);
        chk("midrst_trigger", spi_trigger_out, 1'b0);
        chk("midrst_done", done_out, 1'b0);
        chk("midrst_drop", drop_count_out, 8'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        drop_exp = 0;
        chk("midrst_no_done_pulse", done_count - dc0, 0);
        run_packet(8'($urandom), CW'($urandom), CW'($urandom), 0, 0);

        repeat (5) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
